// File: rtl/seq_fsm_gen.sv
// Table-driven Moore sequence generator with run-time writable next-state/output tables.
// Optional transition counter on step_cnt when SEQ_STEP_CNT_EN is defined.
module seq_fsm_gen #(
  parameter int NUM_STATES  = 8,
  parameter int OUT_W       = 1,
  parameter int START_STATE = 0,
  localparam int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               restart,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  output logic [STATE_W-1:0] state,
  output logic [OUT_W-1:0]   y,
  output logic               cycle_done,
  output logic               stuck,
  output logic               err,
  output logic [15:0]        step_cnt
);

  localparam logic [STATE_W-1:0] START_IDX = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] LAST_IDX  = STATE_W'(NUM_STATES - 1);
  localparam bit                 FULL_MAP  = ((1 << STATE_W) == NUM_STATES);

  // Handshake: none. cfg_we writes are always accepted, one entry per cycle,
  // and en/restart are level controls sampled on every rising clk edge.

  logic [STATE_W-1:0] next_tbl [NUM_STATES];
  logic [OUT_W-1:0]   out_tbl  [NUM_STATES];

  logic [STATE_W-1:0] cur_next;
  logic [STATE_W-1:0] state_d;
  logic               done_d;
  logic               err_d;
  logic               adv;
  logic               next_ok;
  logic               addr_ok;

  assign cur_next = next_tbl[state];
  assign y        = out_tbl[state];
  assign stuck    = (cur_next == state);
  assign adv      = en && !restart;

  // With a power-of-2 state count every encodable index is a real state.
  if (FULL_MAP) begin : g_full
    assign next_ok = 1'b1;
    assign addr_ok = 1'b1;
  end else begin : g_part
    assign next_ok = (cur_next <= LAST_IDX);
    assign addr_ok = (cfg_addr <= LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= START_IDX;
      cycle_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      cycle_done <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_d   = err;
    if (restart) begin
      state_d = START_IDX;
    end else if (adv) begin
      if (!next_ok) begin
        // Out-of-range entry: recover to the start state and latch the error.
        state_d = START_IDX;
        err_d   = 1'b1;
      end else begin
        state_d = cur_next;
        done_d  = (cur_next == START_IDX) && (state != START_IDX);
      end
    end
  end

  // Tables reload their identity-step defaults on every reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        next_tbl[i] <= STATE_W'((i + 1) % NUM_STATES);
        out_tbl[i]  <= OUT_W'(i);
      end
    end else if (cfg_we && addr_ok) begin
      next_tbl[cfg_addr] <= cfg_next;
      out_tbl[cfg_addr]  <= cfg_out;
    end
  end

`ifdef SEQ_STEP_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'h0000;
    end else if (adv && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign step_cnt = cnt_q;
`else
  assign step_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_seq_fsm_gen.sv
// Directed + randomized bench for seq_fsm_gen: N=8 instance against a table model,
// plus an N=6 instance for illegal-entry and ignored-address cases.
module tb_seq_fsm_gen;

  localparam int N  = 8;
  localparam int SW = 3;
  localparam int OW = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en, restart, cfg_we;
  logic [SW-1:0] cfg_addr, cfg_next;
  logic [OW-1:0] cfg_out;
  logic [SW-1:0] state;
  logic [OW-1:0] y;
  logic          cycle_done, stuck, err;
  logic [15:0]   step_cnt;

  logic          en6, restart6, cfg_we6;
  logic [2:0]    cfg_addr6, cfg_next6;
  logic [0:0]    cfg_out6;
  logic [2:0]    state6;
  logic [0:0]    y6;
  logic          cycle_done6, stuck6, err6;
  logic [15:0]   step_cnt6;

  int tests = 0;
  int fails = 0;

  // Reference model: the tables and state as plain integers.
  int m_next [N];
  int m_out  [N];
  int m_state, m_done, m_err, m_cnt;

  always #5 clk = ~clk;

  seq_fsm_gen #(.NUM_STATES(N), .OUT_W(OW), .START_STATE(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .restart(restart),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next), .cfg_out(cfg_out),
    .state(state), .y(y), .cycle_done(cycle_done), .stuck(stuck), .err(err),
    .step_cnt(step_cnt)
  );

  seq_fsm_gen #(.NUM_STATES(6), .OUT_W(1), .START_STATE(0)) dut6 (
    .clk(clk), .reset_n(reset_n), .en(en6), .restart(restart6),
    .cfg_we(cfg_we6), .cfg_addr(cfg_addr6), .cfg_next(cfg_next6), .cfg_out(cfg_out6),
    .state(state6), .y(y6), .cycle_done(cycle_done6), .stuck(stuck6), .err(err6),
    .step_cnt(step_cnt6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef SEQ_STEP_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_next[i] = (i + 1) % N;
      m_out[i]  = i % (1 << OW);
    end
    m_state = 0;
    m_done  = 0;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    int nx;
    if (restart) begin
      m_state = 0;
      m_done  = 0;
    end else if (en) begin
      if (m_cnt < 65535) m_cnt++;
      nx = m_next[m_state];
      if (nx >= N) begin
        m_err   = 1;
        m_state = 0;
        m_done  = 0;
      end else begin
        m_done  = (nx == 0 && m_state != 0) ? 1 : 0;
        m_state = nx;
      end
    end else begin
      m_done = 0;
    end
    if (cfg_we && int'(cfg_addr) < N) begin
      m_next[cfg_addr] = int'(cfg_next);
      m_out[cfg_addr]  = int'(cfg_out);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), m_state);
    chk({tag, ".y"}, 32'(y), m_out[m_state]);
    chk({tag, ".stuck"}, 32'(stuck), (m_next[m_state] == m_state) ? 1 : 0);
    chk({tag, ".cycle_done"}, 32'(cycle_done), m_done);
    chk({tag, ".err"}, 32'(err), m_err);
    chk({tag, ".step_cnt"}, 32'(step_cnt), exp_cnt(m_cnt));
  endtask

  task automatic drive(input logic e, input logic r, input logic we,
                       input int a, input int nx, input int o);
    en       = e;
    restart  = r;
    cfg_we   = we;
    cfg_addr = SW'(a);
    cfg_next = SW'(nx);
    cfg_out  = OW'(o);
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset dropped mid low-phase; outputs must clear before any clk edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, ".state6"}, 32'(state6), 0);
    chk({tag, ".err6"}, 32'(err6), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int legacy_next [N] = '{4, 2, 1, 3, 7, 2, 2, 2};
  int legacy_seq  [8] = '{4, 7, 2, 1, 2, 1, 2, 1};

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    en6 = 0; restart6 = 0; cfg_we6 = 0; cfg_addr6 = '0; cfg_next6 = '0; cfg_out6 = '0;
    do_reset("reset");

    // Default tables: free-running count 0..7 with wrap pulse.
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc("default");
      chk("default.seq", 32'(state), (k + 1) % N);
      chk("default.done", 32'(cycle_done), (k == 7) ? 1 : 0);
    end

    // Legacy sequence programmed with en low.
    for (int a = 0; a < N; a++) begin
      drive(0, 0, 1, a, legacy_next[a], (a == 4 || a == 7) ? 1 : 0);
      cyc("legacy_wr");
    end
    drive(0, 1, 0, 0, 0, 0);
    cyc("legacy_restart");
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc("legacy");
      chk("legacy.seq", 32'(state), legacy_seq[k]);
      chk("legacy.nodone", 32'(cycle_done), 0);
    end

    // Stuck state.
    do_reset("reset_stuck");
    drive(0, 0, 1, 3, 3, 1);
    cyc("stuck_wr3");
    drive(0, 0, 1, 0, 3, 0);
    cyc("stuck_wr0");
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc("stuck");
      chk("stuck.state", 32'(state), 3);
      chk("stuck.flag", 32'(stuck), 1);
    end

    // Write/transition collision at state 2.
    do_reset("reset_coll");
    drive(1, 0, 0, 0, 0, 0);
    cyc("coll_adv");
    cyc("coll_adv");
    drive(1, 0, 1, 2, 5, 0);
    cyc("coll_write");
    chk("coll.old_entry", 32'(state), 3);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc("coll_loop");
    chk("coll.back_at_2", 32'(state), 2);
    cyc("coll_new");
    chk("coll.new_entry", 32'(state), 5);

    // restart beats en; no pulse.
    do_reset("reset_prio");
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc("prio_adv");
    drive(1, 1, 0, 0, 0, 0);
    cyc("prio");
    chk("prio.state", 32'(state), 0);
    chk("prio.nodone", 32'(cycle_done), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), $urandom_range(0, N - 1),
            $urandom_range(0, N - 1), $urandom_range(0, 1));
      cyc("rand");
    end
    drive(1, 0, 0, 0, 0, 0);
    cyc("pre_async");
    do_reset("async_mid");

    // N=6: ignored address, then illegal entry recovery and sticky err.
    drive(0, 0, 0, 0, 0, 0);
    cfg_we6 = 1; cfg_addr6 = 3'd7; cfg_next6 = 3'd0; cfg_out6 = 1'b1;
    cyc("n6_ign");
    chk("n6.ign_err", 32'(err6), 0);
    chk("n6.ign_state", 32'(state6), 0);
    cfg_addr6 = 3'd1; cfg_next6 = 3'd7; cfg_out6 = 1'b0;
    cyc("n6_wr");
    cfg_we6 = 0; en6 = 1;
    cyc("n6_s1");
    chk("n6.to1", 32'(state6), 1);
    chk("n6.y1", 32'(y6), 0);
    chk("n6.stuck", 32'(stuck6), 0);
    chk("n6.err_pre", 32'(err6), 0);
    cyc("n6_ill");
    chk("n6.recover", 32'(state6), 0);
    chk("n6.err", 32'(err6), 1);
    chk("n6.cnt", 32'(step_cnt6), exp_cnt(2));
    en6 = 0; restart6 = 1;
    cyc("n6_restart");
    chk("n6.err_sticky", 32'(err6), 1);
    chk("n6.restart_state", 32'(state6), 0);
    chk("n6.nodone", 32'(cycle_done6), 0);
    restart6 = 0;
    do_reset("n6_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_fsm_gen.md
Name: seq_fsm_gen

Overview:
- Parametrised, table-driven Moore sequence generator. Successor to the team's fixed 8-state sequence FSM.
- State count, output width and start state are parameters. The next-state and output tables can be written at run time, so one block covers every sequence the activity circuits need.
- Adds enable/restart control, loop-completion and stuck-state detection, and out-of-range error reporting.
- Sits between the board clock/reset and downstream LED/decoder logic as a free-running pattern source.

Parameters:
- NUM_STATES, 8, number of states; legal range 2..256.
- STATE_W, $clog2(NUM_STATES), state index width; derived, not overridden.
- OUT_W, 1, width of the per-state Moore output.
- START_STATE, 0, state entered on reset and restart; must be < NUM_STATES.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  advance one transition per cycle when high
- restart  in  1  synchronous return to START_STATE
- cfg_we  in  1  table write strobe
- cfg_addr  in  STATE_W  table entry to write
- cfg_next  in  STATE_W  next-state value to store
- cfg_out  in  OUT_W  output value to store
- state  out  STATE_W  current state index
- y  out  OUT_W  Moore output, out_tbl[state]
- cycle_done  out  1  one-cycle pulse on re-entry to START_STATE
- stuck  out  1  current state's next entry points to itself
- err  out  1  sticky illegal-next-state flag
- step_cnt  out  16  transition counter (optional feature)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values:
  - state=START_STATE, cycle_done=0, err=0, step_cnt=0.
  - next_tbl[i]=(i+1) mod NUM_STATES; out_tbl[i]=i[OUT_W-1:0].
  - Hence y=START_STATE[OUT_W-1:0] and stuck=0 out of reset.
- Reset asserted mid-operation: all of the above apply immediately, including tables; pending cfg writes are lost.
- Per-cycle priority:
  1. restart: state<=START_STATE.
  2. en: state<=next_tbl[state].
  3. otherwise hold.
- restart with en: restart wins, and no cycle_done pulse is generated.
- Illegal entry: if next_tbl[state] >= NUM_STATES when en=1 (possible only for non-power-of-2 N), state<=START_STATE and err<=1. err is cleared only by reset.
- y and stuck are combinational from registered state and tables; zero-cycle latency from state.
- stuck = (next_tbl[state]==state). It does not depend on en.
- cycle_done is registered. It is 1 for exactly the cycle after an en-driven transition from a state != START_STATE into START_STATE.
  - A self-loop on START_STATE does not pulse.
  - restart never pulses.
- Table writes:
  - When cfg_we=1, entry cfg_addr receives both cfg_next and cfg_out at the clock edge.
  - cfg_addr >= NUM_STATES is ignored (no write, no err).
  - Read-before-write: a transition in the same cycle uses the old next_tbl[state]. A new value is visible from the following cycle, including on y.
- No handshake: writes always accepted, 1 per cycle.

Optional Feature:
- Macro SEQ_STEP_CNT_EN.
- Defined: step_cnt increments on every en-driven transition, including self-loops and illegal-entry recovery. It does not increment on restart or hold. It saturates at 16'hFFFF and clears only on reset.
- Undefined: step_cnt tied to 16'h0000, no counter flops, port still present.

Test Plan:
- Reset default, N=8:
  - Stimulus: reset_n low→high, en=1 for 10 cycles.
  - Response: state 0,1,2,…,7,0,1; y alternates 0,1; cycle_done high only in the cycle after state returns to 0.
- Programmed legacy sequence:
  - Stimulus: write next=4,2,1,3,7,2,2,2 for addr 0..7; out=1 for addr 4,7, else 0; restart; en=1.
  - Response: state 0,4,7,2,1,2,1…; y 0,1,1,0,0…; stuck=0; no cycle_done after first leaving 0.
- Stuck state:
  - Stimulus: write next[3]=3, jump via next[0]=3, en=1.
  - Response: state stays 3, stuck=1 continuously, step_cnt keeps incrementing (if SEQ_STEP_CNT_EN).
- Write/transition collision:
  - Stimulus: at state 2 with en=1, write cfg_addr=2, cfg_next=5.
  - Response: next state=3 (old entry); after returning to 2, next=5.
- Illegal entry, N=6:
  - Stimulus: write next[1]=7, en=1 from state 0.
  - Response: state 0→1→0 (START_STATE), err=1 sticky through restart; cleared only by reset_n low.
- Priority and async reset:
  - Stimulus: restart=1 with en=1 at state 5; later drop reset_n mid-clock.
  - Response: state→0 with no cycle_done; reset drives state=0 and step_cnt=0 without waiting for clk.
